// File: rtl/tinyfpga_cfg_pkg.sv
// tinyfpga_cfg_pkg: shared state encoding and header field layout for the config sequencer
package tinyfpga_cfg_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;
    localparam int HDR_TILE_LSB = 0;
    localparam int HDR_TILE_W   = 8;
    localparam int HDR_CNT_LSB  = 8;
    localparam int HDR_CNT_W    = 8;
    localparam int MAX_TILES    = 256;
endpackage

// File: rtl/cfg_tile_decoder.sv
// cfg_tile_decoder: tile id plus enable to one-hot write strobe and out-of-range flag
module cfg_tile_decoder
    import tinyfpga_cfg_pkg::*;
#(
    parameter int NUM_TILES = 16
) (
    input  logic [HDR_TILE_W-1:0] id,
    input  logic                  en,
    output logic [NUM_TILES-1:0]  onehot,
    output logic                  out_of_range
);
    always_comb begin
        for (int i = 0; i < NUM_TILES; i++) onehot[i] = en && (id == HDR_TILE_W'(i));
        out_of_range = en && (int'(id) >= NUM_TILES);
    end
endmodule

// File: rtl/sb_config_sequencer.sv
// sb_config_sequencer: streams header-addressed config words onto the tile config bus
module sb_config_sequencer
    import tinyfpga_cfg_pkg::*;
#(
    parameter int NUM_TILES  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] config_data,
    output logic [NUM_TILES-1:0]  config_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  clr_err
);
    state_t                 state;
    logic [HDR_TILE_W-1:0]  tile_ptr;
    logic [HDR_CNT_W-1:0]   remaining;
    logic                   accept;
    logic [NUM_TILES-1:0]   dec_en;
    logic                   dec_oor;
    assign in_ready = ~hold & ~reset;
    assign accept   = in_valid & in_ready;
    assign busy     = (state == S_LOAD);
    cfg_tile_decoder #(.NUM_TILES(NUM_TILES)) u_dec (
        .id           (tile_ptr),
        .en           (accept && state == S_LOAD),
        .onehot       (dec_en),
        .out_of_range (dec_oor)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            tile_ptr    <= '0;
            remaining   <= '0;
            config_data <= '0;
            config_en   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            config_en <= dec_en;
            done      <= 1'b0;
            if (clr_err) err <= 1'b0;
            if (accept && state == S_IDLE) begin
                tile_ptr  <= in_data[HDR_TILE_LSB +: HDR_TILE_W];
                remaining <= in_data[HDR_CNT_LSB +: HDR_CNT_W];
                if (in_data[HDR_CNT_LSB +: HDR_CNT_W] == '0) done <= 1'b1;
                else state <= S_LOAD;
            end else if (accept) begin
                config_data <= in_data;
                tile_ptr    <= tile_ptr + 1'b1;
                remaining   <= remaining - 1'b1;
                if (dec_oor) err <= 1'b1;
                if (remaining == HDR_CNT_W'(1)) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sb_config_sequencer.sv
// tb_sb_config_sequencer: random and directed stimulus against a burst-level reference model
module tb_sb_config_sequencer;
    logic        clk = 1'b0;
    logic        reset, in_valid, hold, clr_err;
    logic [31:0] in_data;
    logic        in_ready, busy, done, err;
    logic [31:0] config_data;
    logic [15:0] config_en;
    int          n_tests = 0, n_fail = 0;
    logic [39:0] got_q[$], exp_q[$];
    int          m_left;
    logic [7:0]  m_ptr;
    logic        m_load, m_done, m_err;
    logic [31:0] m_data;
    logic [15:0] m_en;

    sb_config_sequencer #(.NUM_TILES(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .hold(hold), .config_data(config_data), .config_en(config_en), .busy(busy),
        .done(done), .err(err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle-level expectation of the bus, derived from accepted words
    always @(posedge clk) begin
        m_en = '0;
        m_done = 1'b0;
        if (reset) begin
            m_left = 0; m_ptr = '0; m_load = 1'b0; m_data = '0; m_err = 1'b0;
        end else begin
            if (clr_err) m_err = 1'b0;
            if (in_valid && !hold) begin
                if (!m_load) begin
                    m_ptr = in_data[7:0];
                    m_left = int'(in_data[15:8]);
                    if (m_left == 0) m_done = 1'b1;
                    else m_load = 1'b1;
                end else begin
                    m_data = in_data;
                    if (m_ptr < 8'd16) m_en = 16'd1 << m_ptr;
                    else m_err = 1'b1;
                    m_ptr = m_ptr + 8'd1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_load = 1'b0; m_done = 1'b1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("config_en", config_en, m_en);
        check("config_data", config_data, m_data);
        check("done", done, m_done);
        check("busy", busy, m_load);
        check("err", err, m_err);
        check("in_ready", in_ready, !hold && !reset);
        check("onehot", $countones(config_en) <= 1, 1);
        for (int i = 0; i < 16; i++) if (config_en[i]) got_q.push_back({8'(i), config_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_data = w;
        tick();
        in_valid = 1'b0;
        in_data = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_burst(input logic [7:0] start, input logic [31:0] words[$]);
        foreach (words[k]) begin
            logic [7:0] t;
            t = start + 8'(k);
            if (t < 8'd16) exp_q.push_back({t, words[k]});
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic burst(input logic [7:0] start, input int n, input bit gaps);
        logic [31:0] w[$];
        send({16'($urandom), 8'(n), start});
        for (int k = 0; k < n; k++) begin
            w.push_back($urandom);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    hold = $urandom_range(0, 1);
                    in_valid = hold;
                    tick();
                end
                hold = 1'b0;
                in_valid = 1'b0;
            end
            send(w[k]);
        end
        expect_burst(start, w);
    endtask

    initial begin
        logic [31:0] w[$];
        reset = 1'b1; in_valid = 1'b0; hold = 1'b0; clr_err = 1'b0; in_data = '0;
        idle(2);
        check("rst_en", config_en, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        idle(1);
        // 1: three-word burst from tile 0
        w = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        send(32'h0000_0300);
        foreach (w[k]) send(w[k]);
        expect_burst(8'd0, w);
        idle(2);
        check("t1_busy", busy, 1'b0);
        compare_log("t1");
        // 2: empty burst
        send(32'h0000_000E);
        check("t2_busy", busy, 1'b0);
        idle(2);
        compare_log("t2");
        // 3: burst running off the end of the array
        w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        send(32'h0000_030E);
        foreach (w[k]) send(w[k]);
        expect_burst(8'd14, w);
        idle(1);
        check("t3_err", err, 1'b1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("t3_clr", err, 1'b0);
        compare_log("t3");
        // 4: hold for three cycles mid-burst
        w = '{$urandom, $urandom, $urandom, $urandom};
        send(32'h0000_0400);
        send(w[0]);
        send(w[1]);
        hold = 1'b1;
        in_valid = 1'b1;
        in_data = w[2];
        repeat (3) begin
            @(negedge clk);
            check("t4_ready", in_ready, 1'b0);
            tick();
        end
        hold = 1'b0;
        in_valid = 1'b0;
        idle($urandom_range(0, 2));
        send(w[2]);
        idle($urandom_range(0, 2));
        send(w[3]);
        expect_burst(8'd0, w);
        idle(2);
        compare_log("t4");
        // 5: reset while word 2 is presented
        w = '{$urandom, $urandom};
        send(32'h0000_0400);
        send(w[0]);
        send(w[1]);
        expect_burst(8'd0, w);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = $urandom;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        idle(2);
        check("t5_busy", busy, 1'b0);
        compare_log("t5");
        burst(8'd5, 2, 1'b0);
        idle(2);
        compare_log("t5_after");
        // 6: two bursts one idle cycle apart
        burst(8'd1, 2, 1'b0);
        idle(1);
        burst(8'd3, 2, 1'b0);
        idle(2);
        compare_log("t6");
        // random bursts, including out-of-range and 255->0 wrap starts
        for (int r = 0; r < 30; r++) begin
            logic [7:0] s;
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 20));
            burst(s, $urandom_range(0, 8), 1'b1);
            clr_err = $urandom_range(0, 3) == 0;
            idle($urandom_range(0, 2));
            clr_err = 1'b0;
        end
        idle(2);
        compare_log("rand");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
